// File: rtl/fast_myfft_x4_pipe.sv
// Pipelined radix-4 butterfly: three register stages under a global valid/ready stall,
// with per-vector rounding right-shift and saturating or wrapping outputs.
module fast_myfft_x4_pipe #(
  parameter int    SIZE_DATA = 16,
  parameter string TYPE      = "forvard",
  parameter int    SAT_EN    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_shift,
  input  logic [SIZE_DATA-1:0] i_data0_in_i,
  input  logic [SIZE_DATA-1:0] i_data1_in_i,
  input  logic [SIZE_DATA-1:0] i_data2_in_i,
  input  logic [SIZE_DATA-1:0] i_data3_in_i,
  input  logic [SIZE_DATA-1:0] i_data0_in_q,
  input  logic [SIZE_DATA-1:0] i_data1_in_q,
  input  logic [SIZE_DATA-1:0] i_data2_in_q,
  input  logic [SIZE_DATA-1:0] i_data3_in_q,
  output logic [SIZE_DATA-1:0] o_data0_out_i,
  output logic [SIZE_DATA-1:0] o_data1_out_i,
  output logic [SIZE_DATA-1:0] o_data2_out_i,
  output logic [SIZE_DATA-1:0] o_data3_out_i,
  output logic [SIZE_DATA-1:0] o_data0_out_q,
  output logic [SIZE_DATA-1:0] o_data1_out_q,
  output logic [SIZE_DATA-1:0] o_data2_out_q,
  output logic [SIZE_DATA-1:0] o_data3_out_q,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_ovf
);

  localparam int W1 = SIZE_DATA + 1;
  localparam int W2 = SIZE_DATA + 2;
  localparam int W3 = SIZE_DATA + 3;
  localparam bit INV = (TYPE == "invers");
  localparam logic signed [W3-1:0] RND1 = W3'(1);
  localparam logic signed [W3-1:0] RND2 = W3'(2);

  function automatic logic signed [W1-1:0] ext1(input logic [SIZE_DATA-1:0] x);
    return {x[SIZE_DATA-1], x};
  endfunction

  function automatic logic signed [W2-1:0] ext2(input logic signed [W1-1:0] x);
    return {x[W1-1], x};
  endfunction

  // Round half toward +inf: add half an LSB of the result, then arithmetic shift.
  function automatic logic signed [W3-1:0] round_shift(input logic signed [W2-1:0] x,
                                                       input logic [1:0] s);
    logic signed [W3-1:0] xe;
    xe = {x[W2-1], x};
    case (s)
      2'd0:    return xe;
      2'd1:    return (xe + RND1) >>> 1;
      default: return (xe + RND2) >>> 2;
    endcase
  endfunction

  function automatic logic out_of_range(input logic signed [W3-1:0] r);
    return !((&r[W3-1:SIZE_DATA-1]) || !(|r[W3-1:SIZE_DATA-1]));
  endfunction

  function automatic logic [SIZE_DATA-1:0] clip(input logic signed [W3-1:0] r);
    logic [SIZE_DATA-1:0] lim;
    if (SAT_EN == 0 || !out_of_range(r)) return r[SIZE_DATA-1:0];
    lim = {SIZE_DATA{!r[W3-1]}};
    lim[SIZE_DATA-1] = r[W3-1];
    return lim;
  endfunction

  logic [SIZE_DATA-1:0] a_i [4];
  logic [SIZE_DATA-1:0] a_q [4];

  assign a_i[0] = i_data0_in_i;
  assign a_i[1] = i_data1_in_i;
  assign a_i[2] = i_data2_in_i;
  assign a_i[3] = i_data3_in_i;
  assign a_q[0] = i_data0_in_q;
  assign a_q[1] = i_data1_in_q;
  assign a_q[2] = i_data2_in_q;
  assign a_q[3] = i_data3_in_q;

  logic stall;
  logic v1_q, v2_q, v3_q;

  logic signed [W1-1:0] s02_i_d, s02_q_d, d02_i_d, d02_q_d;
  logic signed [W1-1:0] s13_i_d, s13_q_d, d13_i_d, d13_q_d;
  logic signed [W1-1:0] s02_i_q, s02_q_q, d02_i_q, d02_q_q;
  logic signed [W1-1:0] s13_i_q, s13_q_q, d13_i_q, d13_q_q;
  logic [1:0]           sh1_d, sh1_q, sh2_q;

  logic signed [W2-1:0] xf_i, xf_q, xb_i, xb_q;
  logic signed [W2-1:0] x_i_d [4];
  logic signed [W2-1:0] x_q_d [4];
  logic signed [W2-1:0] x_i_q [4];
  logic signed [W2-1:0] x_q_q [4];

  logic signed [W3-1:0] r_i [4];
  logic signed [W3-1:0] r_q [4];
  logic [SIZE_DATA-1:0] y_i_d [4];
  logic [SIZE_DATA-1:0] y_q_d [4];
  logic [SIZE_DATA-1:0] y_i_q [4];
  logic [SIZE_DATA-1:0] y_q_q [4];
  logic                 ovf_d, ovf_q;

  assign stall   = v3_q && !i_ready;
  assign o_ready = !stall;

  always_comb begin
    s02_i_d = ext1(a_i[0]) + ext1(a_i[2]);
    s02_q_d = ext1(a_q[0]) + ext1(a_q[2]);
    d02_i_d = ext1(a_i[0]) - ext1(a_i[2]);
    d02_q_d = ext1(a_q[0]) - ext1(a_q[2]);
    s13_i_d = ext1(a_i[1]) + ext1(a_i[3]);
    s13_q_d = ext1(a_q[1]) + ext1(a_q[3]);
    d13_i_d = ext1(a_i[1]) - ext1(a_i[3]);
    d13_q_d = ext1(a_q[1]) - ext1(a_q[3]);
    sh1_d   = (i_shift == 2'd3) ? 2'd2 : i_shift;
  end

  always_comb begin
    xf_i = ext2(d02_i_q) + ext2(d13_q_q);
    xf_q = ext2(d02_q_q) - ext2(d13_i_q);
    xb_i = ext2(d02_i_q) - ext2(d13_q_q);
    xb_q = ext2(d02_q_q) + ext2(d13_i_q);
    x_i_d[0] = ext2(s02_i_q) + ext2(s13_i_q);
    x_q_d[0] = ext2(s02_q_q) + ext2(s13_q_q);
    x_i_d[2] = ext2(s02_i_q) - ext2(s13_i_q);
    x_q_d[2] = ext2(s02_q_q) - ext2(s13_q_q);
    x_i_d[1] = INV ? xb_i : xf_i;
    x_q_d[1] = INV ? xb_q : xf_q;
    x_i_d[3] = INV ? xf_i : xb_i;
    x_q_d[3] = INV ? xf_q : xb_q;
  end

  always_comb begin
    ovf_d = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      r_i[k]   = round_shift(x_i_q[k], sh2_q);
      r_q[k]   = round_shift(x_q_q[k], sh2_q);
      y_i_d[k] = clip(r_i[k]);
      y_q_d[k] = clip(r_q[k]);
      ovf_d    = ovf_d | out_of_range(r_i[k]) | out_of_range(r_q[k]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        y_i_q[k] <= '0;
        y_q_q[k] <= '0;
      end
    end else if (!stall) begin
      v1_q <= i_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      // Outputs only load real vectors, so bubbles leave the last result on the bus.
      if (v2_q) begin
        ovf_q <= ovf_d;
        for (int unsigned k = 0; k < 4; k++) begin
          y_i_q[k] <= y_i_d[k];
          y_q_q[k] <= y_q_d[k];
        end
      end
    end
  end

  // Stage 1-2 data carries no reset; the valid bits alone qualify it.
  always_ff @(posedge i_clk) begin
    if (!stall) begin
      s02_i_q <= s02_i_d;
      s02_q_q <= s02_q_d;
      d02_i_q <= d02_i_d;
      d02_q_q <= d02_q_d;
      s13_i_q <= s13_i_d;
      s13_q_q <= s13_q_d;
      d13_i_q <= d13_i_d;
      d13_q_q <= d13_q_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh1_q;
      for (int unsigned k = 0; k < 4; k++) begin
        x_i_q[k] <= x_i_d[k];
        x_q_q[k] <= x_q_d[k];
      end
    end
  end

  assign o_valid       = v3_q;
  assign o_ovf         = ovf_q;
  assign o_data0_out_i = y_i_q[0];
  assign o_data1_out_i = y_i_q[1];
  assign o_data2_out_i = y_i_q[2];
  assign o_data3_out_i = y_i_q[3];
  assign o_data0_out_q = y_q_q[0];
  assign o_data1_out_q = y_q_q[1];
  assign o_data2_out_q = y_q_q[2];
  assign o_data3_out_q = y_q_q[3];

endmodule

// File: tb/tb_fast_myfft_x4_pipe.sv
// Self-checking bench: a forward/saturating and an inverse/wrapping instance share stimulus,
// checked against a direct 4-point DFT reference.
module tb_fast_myfft_x4_pipe;

  typedef logic [3:0][15:0] v4_t;
  typedef struct packed { v4_t xi; v4_t xq; logic ovf; } res_t;
  typedef struct { v4_t ai; v4_t aq; logic [1:0] sh; v4_t ei; v4_t eq; logic eovf; } vec_t;

  localparam int NT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] shift = 2'd0;
  v4_t        in_i = '0;
  v4_t        in_q = '0;

  logic        f_ready, f_valid, f_ovf, b_ready, b_valid, b_ovf;
  logic [15:0] f_di [4];
  logic [15:0] f_dq [4];
  logic [15:0] b_di [4];
  logic [15:0] b_dq [4];
  res_t        f_res, b_res;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [NT];
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  fast_myfft_x4_pipe #(.SIZE_DATA(16), .TYPE("forvard"), .SAT_EN(1)) dut_fwd (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(f_ready), .i_shift(shift),
    .i_data0_in_i(in_i[0]), .i_data1_in_i(in_i[1]), .i_data2_in_i(in_i[2]), .i_data3_in_i(in_i[3]),
    .i_data0_in_q(in_q[0]), .i_data1_in_q(in_q[1]), .i_data2_in_q(in_q[2]), .i_data3_in_q(in_q[3]),
    .o_data0_out_i(f_di[0]), .o_data1_out_i(f_di[1]), .o_data2_out_i(f_di[2]), .o_data3_out_i(f_di[3]),
    .o_data0_out_q(f_dq[0]), .o_data1_out_q(f_dq[1]), .o_data2_out_q(f_dq[2]), .o_data3_out_q(f_dq[3]),
    .o_valid(f_valid), .i_ready(out_ready), .o_ovf(f_ovf)
  );

  fast_myfft_x4_pipe #(.SIZE_DATA(16), .TYPE("invers"), .SAT_EN(0)) dut_inv (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(b_ready), .i_shift(shift),
    .i_data0_in_i(in_i[0]), .i_data1_in_i(in_i[1]), .i_data2_in_i(in_i[2]), .i_data3_in_i(in_i[3]),
    .i_data0_in_q(in_q[0]), .i_data1_in_q(in_q[1]), .i_data2_in_q(in_q[2]), .i_data3_in_q(in_q[3]),
    .o_data0_out_i(b_di[0]), .o_data1_out_i(b_di[1]), .o_data2_out_i(b_di[2]), .o_data3_out_i(b_di[3]),
    .o_data0_out_q(b_dq[0]), .o_data1_out_q(b_dq[1]), .o_data2_out_q(b_dq[2]), .o_data3_out_q(b_dq[3]),
    .o_valid(b_valid), .i_ready(out_ready), .o_ovf(b_ovf)
  );

  always_comb begin
    f_res = '0;
    b_res = '0;
    for (int k = 0; k < 4; k++) begin
      f_res.xi[k] = f_di[k];
      f_res.xq[k] = f_dq[k];
      b_res.xi[k] = b_di[k];
      b_res.xq[k] = b_dq[k];
    end
    f_res.ovf = f_ovf;
    b_res.ovf = b_ovf;
  end

  function automatic v4_t p4(input int a, input int b, input int c, input int d);
    v4_t v;
    v[0] = 16'(a);
    v[1] = 16'(b);
    v[2] = 16'(c);
    v[3] = 16'(d);
    return v;
  endfunction

  function automatic int scale_ref(input int x, input int s);
    if (s == 0) return x;
    return (x + (1 << (s - 1))) >>> s;
  endfunction

  function automatic logic [15:0] fit(input int y, input bit sat, output bit oor);
    oor = (y > 32767) || (y < -32768);
    if (oor && sat) return (y > 0) ? 16'h7fff : 16'h8000;
    return y[15:0];
  endfunction

  // X[k] = sum_n a[n] * w^(n*k), w = -j forward, +j inverse.
  function automatic res_t model(input v4_t ai, input v4_t aq, input logic [1:0] sh,
                                 input bit inv, input bit sat);
    res_t r;
    int   re, im, xr, xq, m, s;
    bit   o1, o2;
    r = '0;
    s = (sh == 2'd3) ? 2 : int'(sh);
    for (int k = 0; k < 4; k++) begin
      xr = 0;
      xq = 0;
      for (int n = 0; n < 4; n++) begin
        re = int'($signed(ai[n]));
        im = int'($signed(aq[n]));
        m  = (n * k) % 4;
        if (inv) m = (4 - m) % 4;
        case (m)
          0:       begin xr += re; xq += im; end
          1:       begin xr += im; xq -= re; end
          2:       begin xr -= re; xq -= im; end
          default: begin xr -= im; xq += re; end
        endcase
      end
      r.xi[k] = fit(scale_ref(xr, s), sat, o1);
      r.xq[k] = fit(scale_ref(xq, s), sat, o2);
      r.ovf   = r.ovf | o1 | o2;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(0, 7))
      0:       return 16'h7fff;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rnd_vec();
    for (int k = 0; k < 4; k++) begin
      in_i[k] = rnd_sample();
      in_q[k] = rnd_sample();
    end
    shift = 2'($urandom_range(0, 3));
  endtask

  task automatic send_and_wait(input v4_t ai, input v4_t aq, input logic [1:0] sh, output int lat);
    in_i = ai;
    in_q = aq;
    shift = sh;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("accept_ready", f_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!f_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic stream(input string tag, input int nvec, input bit patterned, input int max_cyc);
    res_t qf[$];
    res_t qb[$];
    res_t hold_f, hold_b, got;
    bit   st_f, st_b;
    int   cyc, sent_f, sent_b;
    cyc = 0; sent_f = 0; sent_b = 0; st_f = 0; st_b = 0;
    hold_f = '0; hold_b = '0;
    while (cyc < max_cyc && !(sent_f == nvec && qf.size() == 0 && qb.size() == 0)) begin
      out_ready = patterned ? pat[cyc % 4] : ($urandom_range(0, 3) != 0);
      rnd_vec();
      in_valid = (sent_f < nvec) && (patterned || $urandom_range(0, 2) != 0);
      #1;
      chk({tag, " o_ready fwd"}, f_ready, !(f_valid && !out_ready));
      chk({tag, " o_ready inv"}, b_ready, !(b_valid && !out_ready));
      if (st_f) chk({tag, " stall hold fwd"}, {f_valid, f_res}, {1'b1, hold_f});
      if (st_b) chk({tag, " stall hold inv"}, {b_valid, b_res}, {1'b1, hold_b});
      if (f_valid && out_ready) begin
        chk({tag, " fwd output expected"}, qf.size() != 0, 1'b1);
        if (qf.size() != 0) begin
          got = qf.pop_front();
          chk({tag, " fwd data"}, f_res, got);
        end
      end
      if (b_valid && out_ready) begin
        chk({tag, " inv output expected"}, qb.size() != 0, 1'b1);
        if (qb.size() != 0) begin
          got = qb.pop_front();
          chk({tag, " inv data"}, b_res, got);
        end
      end
      st_f = f_valid && !out_ready;
      st_b = b_valid && !out_ready;
      hold_f = f_res;
      hold_b = b_res;
      if (in_valid && f_ready) begin
        qf.push_back(model(in_i, in_q, shift, 1'b0, 1'b1));
        sent_f++;
      end
      if (in_valid && b_ready) begin
        qb.push_back(model(in_i, in_q, shift, 1'b1, 1'b0));
        sent_b++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, " accepted fwd"}, sent_f, nvec);
    chk({tag, " accepted inv"}, sent_b, nvec);
    chk({tag, " drained"}, qf.size() + qb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int   lat, pulses, first;
    res_t exp_f, exp_b;

    tbl[0] = '{p4(1000, 1000, 1000, 1000), p4(0, 0, 0, 0), 2'd0,
               p4(4000, 0, 0, 0), p4(0, 0, 0, 0), 1'b0};
    tbl[1] = '{p4(100, 0, 0, 0), p4(0, 100, 0, 0), 2'd0,
               p4(100, 200, 100, 0), p4(100, 0, -100, 0), 1'b0};
    tbl[2] = '{p4(32767, 32767, 32767, 32767), p4(32767, 32767, 32767, 32767), 2'd0,
               p4(32767, 0, 0, 0), p4(32767, 0, 0, 0), 1'b1};
    tbl[3] = '{p4(32767, 32767, 32767, 32767), p4(32767, 32767, 32767, 32767), 2'd2,
               p4(32767, 0, 0, 0), p4(32767, 0, 0, 0), 1'b0};
    tbl[4] = '{p4(3, 0, 0, 0), p4(-3, 0, 0, 0), 2'd2,
               p4(1, 1, 1, 1), p4(-1, -1, -1, -1), 1'b0};
    tbl[5] = '{p4(3, 0, 0, 0), p4(-3, 0, 0, 0), 2'd1,
               p4(2, 2, 2, 2), p4(-1, -1, -1, -1), 1'b0};
    tbl[6] = '{p4(3, 0, 0, 0), p4(-3, 0, 0, 0), 2'd3,
               p4(1, 1, 1, 1), p4(-1, -1, -1, -1), 1'b0};
    tbl[7] = '{p4(-32768, -32768, -32768, -32768), p4(-32768, -32768, -32768, -32768), 2'd0,
               p4(-32768, 0, 0, 0), p4(-32768, 0, 0, 0), 1'b1};
    tbl[8] = '{p4(-32768, -32768, -32768, -32768), p4(-32768, -32768, -32768, -32768), 2'd1,
               p4(-32768, 0, 0, 0), p4(-32768, 0, 0, 0), 1'b1};
    tbl[9] = '{p4(-32768, -32768, -32768, -32768), p4(-32768, -32768, -32768, -32768), 2'd2,
               p4(-32768, 0, 0, 0), p4(-32768, 0, 0, 0), 1'b0};

    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset fwd state", {f_valid, f_res}, '0);
    chk("reset inv state", {b_valid, b_res}, '0);
    chk("reset o_ready", {f_ready, b_ready}, 2'b11);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < NT; t++) begin
      send_and_wait(tbl[t].ai, tbl[t].aq, tbl[t].sh, lat);
      chk($sformatf("vec%0d latency", t), lat, 3);
      chk($sformatf("vec%0d fwd", t), f_res, {tbl[t].ei, tbl[t].eq, tbl[t].eovf});
      chk($sformatf("vec%0d inv valid", t), b_valid, 1'b1);
      chk($sformatf("vec%0d inv", t), b_res, model(tbl[t].ai, tbl[t].aq, tbl[t].sh, 1'b1, 1'b0));
      @(negedge clk);
      chk($sformatf("vec%0d single pulse", t), {f_valid, b_valid}, 2'b00);
    end

    stream("bp10", 10, 1'b1, 200);
    stream("rand", 300, 1'b0, 4000);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_vec();
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("inflight valid", f_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrun reset fwd", {f_valid, f_res}, '0);
    chk("midrun reset inv", {b_valid, b_res}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    rnd_vec();
    exp_f = model(in_i, in_q, shift, 1'b0, 1'b1);
    exp_b = model(in_i, in_q, shift, 1'b1, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("post reset ready", f_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0;
    first = 0;
    for (int c = 1; c <= 12; c++) begin
      if (f_valid) begin
        pulses++;
        if (first == 0) begin
          first = c;
          chk("post reset fwd", f_res, exp_f);
          chk("post reset inv", {b_valid, b_res}, {1'b1, exp_b});
        end
      end
      @(negedge clk);
    end
    chk("post reset latency", first, 3);
    chk("post reset pulses", pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
